// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

    localparam int unsigned SAR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StTest,
        StDone
    } sar_state_e;

endpackage

// File: rtl/sar_ptr.sv
// One-hot bit pointer: loads the MSB position, then walks right one bit per shift.
module sar_ptr
    import sar_pkg::*;
#(
    parameter int unsigned W = SAR_W_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         shift_i,
    output logic [W-1:0] ptr_o,
    output logic         is_lsb_o
);

    localparam logic [W-1:0] MsbOnly = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = MsbOnly;
        end else if (shift_i) begin
            ptr_d = ptr_q >> 1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o    = ptr_q;
    assign is_lsb_o = ptr_q[0];

endmodule

// File: rtl/sar_search.sv
// Successive-approximation master: drives trial guesses into an external comparator
// and binary-searches the target from its greater/equal/smaller responses.
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned W = SAR_W_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         g_i,
    input  logic         e_i,
    input  logic         s_i,
    output logic [W-1:0] guess_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         found_o,
    output logic         err_o
);

    localparam logic [W-1:0] MsbOnly = {1'b1, {(W-1){1'b0}}};

    sar_state_e   state_q, state_d;
    logic [W-1:0] guess_q, guess_d;
    logic [W-1:0] result_q, result_d;
    logic         found_q, found_d;
    logic         err_q, err_d;

    logic [W-1:0] ptr;
    logic         is_lsb;
    logic         in_test;
    logic         accept;
    logic         one_hot;
    logic         terminal;
    logic         shift;

    assign in_test  = (state_q == StTest);
    assign accept   = start_i && (state_q == StIdle || state_q == StDone);
    assign one_hot  = (g_i && !e_i && !s_i) || (!g_i && e_i && !s_i) || (!g_i && !e_i && s_i);
    // Any bad flag pattern, an exact hit, or the last bit ends the search.
    assign terminal = !one_hot || e_i || is_lsb;
    assign shift    = in_test && !terminal;

    sar_ptr #(
        .W(W)
    ) u_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (accept),
        .shift_i (shift),
        .ptr_o   (ptr),
        .is_lsb_o(is_lsb)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StTest;
            StTest:  if (terminal) state_d = StDone;
            StDone:  state_d = start_i ? StTest : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q == StTest);
        done_o = (state_q == StDone);
    end

    always_comb begin
        guess_d  = guess_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
        if (accept) begin
            guess_d = MsbOnly;
            found_d = 1'b0;
            err_d   = 1'b0;
        end else if (in_test) begin
            if (!one_hot) begin
                result_d = guess_q;
                found_d  = 1'b0;
                err_d    = 1'b1;
            end else if (e_i) begin
                result_d = guess_q;
                found_d  = 1'b1;
            end else if (is_lsb) begin
                if (s_i) begin
                    result_d = guess_q & ~ptr;
                    found_d  = 1'b1;
                end else begin
                    // Target above an all-bits-resolved guess cannot happen honestly.
                    result_d = guess_q;
                    found_d  = 1'b0;
                    err_d    = 1'b1;
                end
            end else if (g_i) begin
                guess_d = guess_q | (ptr >> 1);
            end else begin
                guess_d = (guess_q & ~ptr) | (ptr >> 1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            guess_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            guess_q  <= guess_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign guess_o  = guess_q;
    assign result_o = result_q;
    assign found_o  = found_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural comparator and fault-injection mux.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       g, e, s;
    logic [3:0] guess, result;
    logic       busy, done, found, err;

    logic [3:0] target = 4'd0;
    int         fault_mode = 0;
    logic [3:0] seen_guess [1:12];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    // 0: honest comparator, 1: force g at guess 0001, 2: force g=e=1 always
    always_comb begin
        g = (target > guess);
        e = (target == guess);
        s = (target < guess);
        if (fault_mode == 1 && guess == 4'b0001) begin
            g = 1'b1; e = 1'b0; s = 1'b0;
        end else if (fault_mode == 2) begin
            g = 1'b1; e = 1'b1; s = 1'b0;
        end
    end

    sar_search #(
        .W(4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .g_i     (g),
        .e_i     (e),
        .s_i     (s),
        .guess_o (guess),
        .busy_o  (busy),
        .done_o  (done),
        .result_o(result),
        .found_o (found),
        .err_o   (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at #1 after an edge while idle or done; returns the cycle of the done pulse.
    task automatic run_search(input logic [3:0] tgt, input bit pulse_mid, output int lat);
        target = tgt;
        start  = 1'b1;
        step();
        start  = 1'b0;
        lat    = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            seen_guess[c] = guess;
            if (done) begin
                lat = c;
            end else begin
                start = (pulse_mid && c < 3);
                step();
            end
        end
        start = 1'b0;
        if (lat == 0) begin
            $display("FAIL timeout target=%0d: no done within 12 cycles", tgt);
            n_bad++;
            n_cmp++;
        end
    endtask

    function automatic int exp_lat(input logic [3:0] t);
        int tz;
        if (t == 4'd0) return 5;
        tz = 0;
        while (t[tz] == 1'b0) tz++;
        return 4 - tz + 1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2;
        if ({guess, result, found, err, done, busy} !== 12'd0) begin
            $display("FAIL reset_outputs: got %b want 0", {guess, result, found, err, done, busy});
            n_bad++;
        end
        n_cmp++;
        step();
        rst = 1'b0;
        step();
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_target8();
        target = 4'd8;
        start  = 1'b1;
        step();
        start  = 1'b0;
        if (guess !== 4'b1000 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL t8_cycle1: guess=%b busy=%b done=%b want 1000 1 0", guess, busy, done);
            n_bad++;
        end
        n_cmp++;
        step();
        if ({done, busy, result, found, err} !== {1'b1, 1'b0, 4'b1000, 1'b1, 1'b0}) begin
            $display("FAIL t8_cycle2: done=%b busy=%b result=%b found=%b err=%b want 1 0 1000 1 0",
                     done, busy, result, found, err);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_edges();
        int lat;
        run_search(4'd15, 1'b0, lat);
        if ({seen_guess[1], seen_guess[2], seen_guess[3], seen_guess[4]} !== 16'b1000_1100_1110_1111) begin
            $display("FAIL t15_guesses: got %b %b %b %b want 1000 1100 1110 1111",
                     seen_guess[1], seen_guess[2], seen_guess[3], seen_guess[4]);
            n_bad++;
        end
        n_cmp++;
        if (lat !== 5 || result !== 4'b1111 || found !== 1'b1) begin
            $display("FAIL t15_done: lat=%0d result=%b found=%b want 5 1111 1", lat, result, found);
            n_bad++;
        end
        n_cmp++;
        step();
        run_search(4'd0, 1'b0, lat);
        if ({seen_guess[1], seen_guess[2], seen_guess[3], seen_guess[4]} !== 16'b1000_0100_0010_0001) begin
            $display("FAIL t0_guesses: got %b %b %b %b want 1000 0100 0010 0001",
                     seen_guess[1], seen_guess[2], seen_guess[3], seen_guess[4]);
            n_bad++;
        end
        n_cmp++;
        if (lat !== 5 || result !== 4'b0000 || found !== 1'b1 || err !== 1'b0) begin
            $display("FAIL t0_done: lat=%0d result=%b found=%b err=%b want 5 0000 1 0",
                     lat, result, found, err);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_sweep();
        int lat;
        for (int t = 0; t < 16; t++) begin
            step();
            run_search(4'(t), 1'b0, lat);
            if (result !== 4'(t) || found !== 1'b1 || err !== 1'b0 || lat !== exp_lat(4'(t))) begin
                $display("FAIL sweep_%0d: result=%0d found=%b err=%b lat=%0d want %0d 1 0 %0d",
                         t, result, found, err, lat, t, exp_lat(4'(t)));
                n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_faults();
        int lat;
        step();
        fault_mode = 1;
        run_search(4'd0, 1'b0, lat);
        fault_mode = 0;
        if (lat !== 5 || found !== 1'b0 || err !== 1'b1 || result !== 4'b0001) begin
            $display("FAIL fault_lsb_g: lat=%0d found=%b err=%b result=%b want 5 0 1 0001",
                     lat, found, err, result);
            n_bad++;
        end
        n_cmp++;
        step();
        fault_mode = 2;
        run_search(4'd3, 1'b0, lat);
        fault_mode = 0;
        if (lat !== 2 || found !== 1'b0 || err !== 1'b1 || result !== 4'b1000) begin
            $display("FAIL fault_multi: lat=%0d found=%b err=%b result=%b want 2 0 1 1000",
                     lat, found, err, result);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_start_ignored();
        int lat;
        step();
        run_search(4'd5, 1'b1, lat);
        if ({seen_guess[1], seen_guess[2], seen_guess[3], seen_guess[4]} !== 16'b1000_0100_0110_0101) begin
            $display("FAIL midstart_guesses: got %b %b %b %b want 1000 0100 0110 0101",
                     seen_guess[1], seen_guess[2], seen_guess[3], seen_guess[4]);
            n_bad++;
        end
        n_cmp++;
        if (lat !== 5 || result !== 4'd5 || found !== 1'b1) begin
            $display("FAIL midstart_done: lat=%0d result=%0d found=%b want 5 5 1", lat, result, found);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int lat;
        step();
        fault_mode = 2;
        run_search(4'd6, 1'b0, lat);
        // Still in the DONE cycle: restart immediately with an honest comparator.
        fault_mode = 0;
        target = 4'd6;
        start  = 1'b1;
        step();
        start  = 1'b0;
        if ({busy, done, guess, found, err} !== {1'b1, 1'b0, 4'b1000, 1'b0, 1'b0}) begin
            $display("FAIL b2b_restart: busy=%b done=%b guess=%b found=%b err=%b want 1 0 1000 0 0",
                     busy, done, guess, found, err);
            n_bad++;
        end
        n_cmp++;
        lat = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            if (done) lat = c;
            else step();
        end
        if (lat !== 4 || result !== 4'd6 || found !== 1'b1 || err !== 1'b0) begin
            $display("FAIL b2b_done: lat=%0d result=%0d found=%b err=%b want 4 6 1 0",
                     lat, result, found, err);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_rst_mid();
        int lat;
        int saw_done;
        step();
        target = 4'd5;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        if ({guess, busy, done, result, found, err} !== 12'd0) begin
            $display("FAIL rst_async: guess=%b busy=%b done=%b result=%b found=%b err=%b want all 0",
                     guess, busy, done, result, found, err);
            n_bad++;
        end
        n_cmp++;
        saw_done = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done) saw_done++;
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (done || busy) saw_done++;
        end
        if (saw_done !== 0) begin
            $display("FAIL rst_quiet: %0d cycles with done/busy, want 0", saw_done);
            n_bad++;
        end
        n_cmp++;
        run_search(4'd12, 1'b0, lat);
        if (lat !== 3 || result !== 4'd12 || found !== 1'b1 || err !== 1'b0) begin
            $display("FAIL rst_resume: lat=%0d result=%0d found=%b err=%b want 3 12 1 0",
                     lat, result, found, err);
            n_bad++;
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_target8();
        step();
        test_edges();
        test_sweep();
        test_faults();
        test_start_ignored();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
